// File: rtl/redmule_tcdm_responder_if.sv
// HCI core request/response bundle between the RedMulE streamer (master)
// and a TCDM target (slave); includes the ECC side fields for completeness.
interface redmule_tcdm_responder_if #(
  parameter int unsigned DW = 288,
  parameter int unsigned AW = 32,
  parameter int unsigned UW = 1,
  parameter int unsigned IW = 8,
  parameter int unsigned EW = 1
);
  logic            req;
  logic            gnt;
  logic [AW-1:0]   add;
  logic            wen;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   data;
  logic [UW-1:0]   user;
  logic [IW-1:0]   id;
  logic            egnt;
  logic            r_ready;
  logic            r_valid;
  logic [DW-1:0]   r_data;
  logic [UW-1:0]   r_user;
  logic [IW-1:0]   r_id;
  logic            r_opc;
  logic            r_evalid;
  logic [EW-1:0]   r_ecc;

  modport master (
    output req, add, wen, be, data, user, id, r_ready,
    input  gnt, egnt, r_valid, r_data, r_user, r_id, r_opc, r_evalid, r_ecc
  );

  modport slave (
    input  req, add, wen, be, data, user, id, r_ready,
    output gnt, egnt, r_valid, r_data, r_user, r_id, r_opc, r_evalid, r_ecc
  );
endinterface

// File: rtl/redmule_tcdm_responder.sv
// Single-port wide-word scratchpad acting as a TCDM target, with byte-enable
// writes and an in-order bounded response FIFO.
module redmule_tcdm_responder #(
  parameter int unsigned DW        = 288,
  parameter int unsigned AW        = 32,
  parameter int unsigned UW        = 1,
  parameter int unsigned IW        = 8,
  parameter int unsigned NumWords  = 1024,
  parameter int unsigned RespDepth = 4,
  localparam int unsigned OccW     = $clog2(RespDepth + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        clear_i,
  input  logic                        enable_i,
  redmule_tcdm_responder_if.slave     tcdm,
  output logic [OccW-1:0]             occupancy_o,
  output logic                        misaligned_o
);
  localparam int unsigned NB      = DW / 8;
  localparam int unsigned OffBits = $clog2(NB);
  localparam int unsigned IdxBits = $clog2(NumWords);
  localparam int unsigned PtrW    = $clog2(RespDepth);
  localparam logic [AW-1:0] OffMask = AW'((1 << OffBits) - 1);

  typedef struct packed {
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic [IW-1:0] id;
  } resp_t;

  logic [DW-1:0]    mem_q [NumWords];
  resp_t            fifo_q [RespDepth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  cnt_q, cnt_d;
  logic             mis_q, mis_d;
  logic [IdxBits-1:0] idx;
  logic             full, empty, accept, pop;
  resp_t            push_entry;

  assign idx    = tcdm.add[OffBits +: IdxBits];
  assign full   = (cnt_q == OccW'(RespDepth));
  assign empty  = (cnt_q == '0);
  assign accept = tcdm.req & tcdm.gnt;
  assign pop    = ~empty & tcdm.r_ready;

  assign tcdm.gnt      = enable_i & ~clear_i & ~full;
  assign tcdm.egnt     = 1'b0;
  assign tcdm.r_valid  = ~empty;
  assign tcdm.r_opc    = 1'b0;
  assign tcdm.r_evalid = 1'b0;
  assign tcdm.r_ecc    = '0;
  // Stale FIFO slots are masked so an empty queue always shows zeros.
  assign tcdm.r_data   = empty ? '0 : fifo_q[rd_ptr_q].data;
  assign tcdm.r_user   = empty ? '0 : fifo_q[rd_ptr_q].user;
  assign tcdm.r_id     = empty ? '0 : fifo_q[rd_ptr_q].id;

  assign occupancy_o  = cnt_q;
  assign misaligned_o = mis_q;

  always_comb begin
    push_entry.data = tcdm.wen ? mem_q[idx] : '0;
    push_entry.user = tcdm.user;
    push_entry.id   = tcdm.id;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    mis_d    = mis_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      mis_d    = 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_d = (wr_ptr_q == PtrW'(RespDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        if (|(tcdm.add & OffMask)) mis_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PtrW'(RespDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      cnt_d = cnt_q + OccW'(accept) - OccW'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      mis_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mis_q    <= mis_d;
    end
  end

  // Payload storage needs no reset: pointers and count alone define validity.
  always_ff @(posedge clk_i) begin
    if (accept) fifo_q[wr_ptr_q] <= push_entry;
  end

  always_ff @(posedge clk_i) begin
    if (accept && !tcdm.wen) begin
      for (int b = 0; b < NB; b++) begin
        if (tcdm.be[b]) mem_q[idx][b*8 +: 8] <= tcdm.data[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Self-checking bench: vector table plus hand sequences, with a response
// scoreboard fed on accept and drained on each r_valid/r_ready handshake.
module tb_redmule_tcdm_responder;
  localparam logic [287:0] PA5 = {36{8'hA5}};
  localparam logic [287:0] PFF = {36{8'hFF}};
  localparam logic [287:0] P99 = {36{8'h99}};
  localparam logic [287:0] P77 = {36{8'h77}};
  localparam logic [287:0] PC3 = {36{8'hC3}};
  localparam logic [287:0] PE1 = {36{8'hE1}};
  localparam logic [287:0] P5C = {36{8'h5C}};
  localparam logic [287:0] P12 = {{35{8'hFF}}, 8'h12};
  localparam logic [287:0] PW3 = {{35{8'h5A}}, 8'h12};
  localparam logic [287:0] PEDGE = {8'hC3, {34{8'h00}}, 8'hC3};
  localparam logic [35:0]  BE_ALL = {36{1'b1}};

  typedef struct {
    logic         wen;
    logic [31:0]  add;
    logic [35:0]  be;
    logic [287:0] data;
    logic [7:0]   id;
    logic [3:0]   user;
    logic [287:0] exp;
  } vec_t;

  typedef struct {
    logic [287:0] data;
    logic [3:0]   user;
    logic [7:0]   id;
  } sb_t;

  logic clk = 1'b0;
  logic rst_n, clear, enable;
  logic [2:0] occ;
  logic mis;
  logic [287:0] cur_exp;
  sb_t sb_q[$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  redmule_tcdm_responder_if #(.DW(288), .AW(32), .UW(4), .IW(8), .EW(1)) bus ();

  redmule_tcdm_responder #(
    .DW(288), .AW(32), .UW(4), .IW(8), .NumWords(1024), .RespDepth(4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .enable_i    (enable),
    .tcdm        (bus),
    .occupancy_o (occ),
    .misaligned_o(mis)
  );

  task automatic chk(input string name, input logic [287:0] act, input logic [287:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [31:0] add, input logic [35:0] be,
                       input logic [287:0] data, input logic [7:0] id, input logic [3:0] user,
                       input logic [287:0] exp);
    bus.req  = 1'b1;
    bus.wen  = wen;
    bus.add  = add;
    bus.be   = be;
    bus.data = data;
    bus.id   = id;
    bus.user = user;
    cur_exp  = exp;
  endtask

  task automatic issue(input vec_t v);
    int n;
    n = 0;
    drive(v.wen, v.add, v.be, v.data, v.id, v.user, v.exp);
    @(negedge clk);
    while (!bus.gnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("issue_grant", bus.gnt, 1);
    step();
    bus.req = 1'b0;
  endtask

  task automatic rd(input logic [31:0] add, input logic [7:0] id, input logic [287:0] exp);
    vec_t v;
    v = '{1'b1, add, BE_ALL, {9{$urandom()}}, id, id[3:0], exp};
    issue(v);
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.r_ready = 1'b1;
    @(negedge clk);
    while (occ != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_occ", occ, 0);
    chk("drain_sb", sb_q.size(), 0);
    step();
  endtask

  // Scoreboard: pops compare the head, accepts push the bench's expectation.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n || clear) begin
      sb_q.delete();
    end else begin
      if (bus.r_valid && bus.r_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_resp: got id %0h expected no response", bus.r_id);
        end else begin
          e = sb_q.pop_front();
          chk("resp_data", bus.r_data, e.data);
          chk("resp_id", bus.r_id, e.id);
          chk("resp_user", bus.r_user, e.user);
        end
      end
      if (bus.req && bus.gnt) sb_q.push_back('{cur_exp, bus.user, bus.id});
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[13];
    int grants;

    tbl[0]  = '{1'b0, 32'h40,    BE_ALL,     PA5, 8'hA0, 4'h1, '0};
    tbl[1]  = '{1'b1, 32'h40,    BE_ALL,     P99, 8'hA1, 4'h2, PA5};
    tbl[2]  = '{1'b0, 32'hC0,    BE_ALL,     PFF, 8'hA2, 4'h3, '0};
    tbl[3]  = '{1'b0, 32'hC0,    36'h1,      PW3, 8'hA3, 4'h4, '0};
    tbl[4]  = '{1'b1, 32'hC0,    36'h0,      P99, 8'hA4, 4'h5, P12};
    tbl[5]  = '{1'b0, 32'h80,    BE_ALL,     '0,  8'hA5, 4'h6, '0};
    tbl[6]  = '{1'b0, 32'h80,    36'h800000001, PC3, 8'hA6, 4'h7, '0};
    tbl[7]  = '{1'b1, 32'h80,    BE_ALL,     P99, 8'hA7, 4'h8, PEDGE};
    tbl[8]  = '{1'b0, 32'h10000, BE_ALL,     P77, 8'hA8, 4'h9, '0};
    tbl[9]  = '{1'b1, 32'h0,     BE_ALL,     '0,  8'hA9, 4'hA, P77};
    tbl[10] = '{1'b1, 32'h40,    BE_ALL,     '0,  8'hAA, 4'hB, PA5};
    tbl[11] = '{1'b0, 32'hFFC0,  BE_ALL,     PE1, 8'hAB, 4'hC, '0};
    tbl[12] = '{1'b1, 32'h1FFC0, BE_ALL,     P99, 8'hAC, 4'hD, PE1};

    rst_n = 1'b0; clear = 1'b0; enable = 1'b1;
    bus.req = 1'b0; bus.wen = 1'b1; bus.add = '0; bus.be = '0; bus.data = '0;
    bus.id = '0; bus.user = '0; bus.r_ready = 1'b1; cur_exp = '0;
    #22 rst_n = 1'b1;
    step();

    @(negedge clk);
    chk("rst_valid", bus.r_valid, 0);
    chk("rst_occ", occ, 0);
    chk("rst_mis", mis, 0);
    chk("rst_rdata", bus.r_data, 0);
    chk("rst_rid", bus.r_id, 0);
    chk("rst_ruser", bus.r_user, 0);
    chk("rst_gnt", bus.gnt, 1);
    chk("ecc_tieoff", {bus.egnt, bus.r_evalid, bus.r_ecc, bus.r_opc}, 0);
    step();

    for (int i = 0; i < 13; i++) issue(tbl[i]);
    drain();
    @(negedge clk);
    chk("aligned_mis", mis, 0);
    step();

    // Backpressure fill: six one-cycle read attempts, only four fit.
    bus.r_ready = 1'b0;
    grants = 0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h40, BE_ALL, {9{$urandom()}}, 8'(16 + i), 4'(i), PA5);
      @(negedge clk);
      if (bus.gnt) grants++;
      step();
    end
    bus.req = 1'b0;
    @(negedge clk);
    chk("bp_grants", grants, 4);
    chk("bp_occ", occ, 4);
    chk("bp_gnt", bus.gnt, 0);
    chk("bp_head_id", bus.r_id, 16);
    step();
    @(negedge clk);
    chk("bp_stable_data", bus.r_data, PA5);
    chk("bp_stable_id", bus.r_id, 16);
    step();
    bus.r_ready = 1'b1;
    @(negedge clk);
    chk("bp_gnt_at_pop", bus.gnt, 0);
    step();
    @(negedge clk);
    chk("bp_gnt_after_pop", bus.gnt, 1);
    chk("bp_occ_after_pop", occ, 3);
    step();
    drain();

    // Streaming at full-1: accept and pop every cycle.
    bus.r_ready = 1'b0;
    for (int i = 0; i < 3; i++) rd(32'hC0, 8'(32 + i), P12);
    @(negedge clk);
    chk("stream_prefill_occ", occ, 3);
    step();
    bus.r_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'hC0, BE_ALL, {9{$urandom()}}, 8'(40 + i), 4'(i), P12);
      @(negedge clk);
      chk("stream_occ", occ, 3);
      chk("stream_gnt", bus.gnt, 1);
      step();
    end
    bus.req = 1'b0;
    drain();

    // Misaligned wrap read lands on word 0.
    rd(32'h10001, 8'h60, P77);
    drain();
    @(negedge clk);
    chk("mis_set", mis, 1);
    step();

    // Disabled: no grants, queued response still drains.
    bus.r_ready = 1'b0;
    rd(32'h40, 8'h61, PA5);
    enable = 1'b0;
    drive(1'b1, 32'h40, BE_ALL, '0, 8'h62, 4'h2, PA5);
    @(negedge clk);
    chk("dis_gnt", bus.gnt, 0);
    chk("dis_occ", occ, 1);
    step();
    bus.r_ready = 1'b1;
    @(negedge clk);
    chk("dis_valid", bus.r_valid, 1);
    step();
    @(negedge clk);
    chk("dis_drained", occ, 0);
    chk("dis_empty_valid", bus.r_valid, 0);
    step();
    bus.req = 1'b0;
    enable = 1'b1;

    // Clear with a pending response and a request in the same cycle.
    bus.r_ready = 1'b0;
    rd(32'h40, 8'h63, PA5);
    clear = 1'b1;
    drive(1'b1, 32'h40, BE_ALL, '0, 8'h64, 4'h4, PA5);
    @(negedge clk);
    chk("clr_gnt", bus.gnt, 0);
    step();
    clear = 1'b0;
    bus.req = 1'b0;
    @(negedge clk);
    chk("clr_occ", occ, 0);
    chk("clr_mis", mis, 0);
    chk("clr_valid", bus.r_valid, 0);
    step();
    drain();

    // Async reset with three responses pending.
    bus.r_ready = 1'b0;
    for (int i = 0; i < 3; i++) rd(32'h40, 8'(80 + i), PA5);
    @(negedge clk);
    chk("rstmid_occ_before", occ, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid_valid", bus.r_valid, 0);
    chk("rstmid_occ", occ, 0);
    sb_q.delete();
    step();
    rst_n = 1'b1;
    step();
    bus.r_ready = 1'b1;
    drive(1'b0, 32'h100, BE_ALL, P5C, 8'h90, 4'h0, '0);
    @(negedge clk);
    chk("post_rst_wr_gnt", bus.gnt, 1);
    step();
    drive(1'b1, 32'h100, BE_ALL, '0, 8'h91, 4'h1, P5C);
    @(negedge clk);
    chk("post_rst_rd_gnt", bus.gnt, 1);
    step();
    bus.req = 1'b0;
    @(negedge clk);
    chk("lat_valid", bus.r_valid, 1);
    chk("lat_id", bus.r_id, 8'h91);
    chk("lat_data", bus.r_data, P5C);
    step();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
